// File: rtl/fourbool_evaluator.sv
// +----------------------------------------------------------------------------+
// | Module      : fourbool_evaluator                                           |
// | Description : Exhaustive 4-in/4-out fitness evaluator for evolved boolean  |
// |               candidates. Optional macro FOURBOOL_EVAL_FIRST_FAIL_EN adds  |
// |               capture of the first failing input vector.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fourbool_evaluator #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] expected_table,
   input  logic [3:0]  dut_out,
   output logic [3:0]  dut_in,
   output logic        busy,
   output logic        done,
   output logic [6:0]  score,
   output logic [4:0]  vectors_passed,
   output logic        perfect
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
   ,
   output logic        first_fail_valid,
   output logic [3:0]  first_fail_vector
`endif
);

   localparam logic [7:0] c_reload = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [7:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [6:0]  r_score;
   logic [4:0]  r_passed;
   logic        r_perfect;
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
   logic        r_ff_valid;
   logic [3:0]  r_ff_vector;
`endif

   logic [3:0]  w_nib;
   logic [3:0]  w_hit;
   logic [2:0]  w_matches;
   logic        w_all;
   logic [6:0]  w_score_next;

   // Case equality makes X/Z on the candidate outputs count as mismatches.
   always_comb begin
      w_nib     = expected_table[{r_idx, 2'b00} +: 4];
      w_matches = 3'd0;
      for (int b = 0; b < 4; b++) begin
         w_hit[b]  = (dut_out[b] === w_nib[b]);
         w_matches = w_matches + {2'b00, w_hit[b]};
      end
      w_all        = &w_hit;
      w_score_next = r_score + {4'b0000, w_matches};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= 4'd0;
         r_cnt       <= 8'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_score     <= 7'd0;
         r_passed    <= 5'd0;
         r_perfect   <= 1'b0;
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
         r_ff_valid  <= 1'b0;
         r_ff_vector <= 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state     <= S_SETTLE;
                  r_idx       <= 4'd0;
                  r_cnt       <= c_reload;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_score     <= 7'd0;
                  r_passed    <= 5'd0;
                  r_perfect   <= 1'b0;
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
                  r_ff_valid  <= 1'b0;
                  r_ff_vector <= 4'd0;
`endif
               end
            end
            S_SETTLE: begin
               if (r_cnt == 8'd0) r_state <= S_SAMPLE;
               else               r_cnt   <= r_cnt - 8'd1;
            end
            S_SAMPLE: begin
               r_score  <= w_score_next;
               r_passed <= r_passed + {4'b0000, w_all};
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
               if (!w_all && !r_ff_valid) begin
                  r_ff_valid  <= 1'b1;
                  r_ff_vector <= r_idx;
               end
`endif
               if (r_idx == 4'hF) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_perfect <= (w_score_next == 7'd64);
               end else begin
                  r_state <= S_SETTLE;
                  r_idx   <= r_idx + 4'd1;
                  r_cnt   <= c_reload;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The vector index register drives the candidate directly, so it is glitch-free.
   assign dut_in         = r_idx;
   assign busy           = r_busy;
   assign done           = r_done;
   assign score          = r_score;
   assign vectors_passed = r_passed;
   assign perfect        = r_perfect;
`ifdef FOURBOOL_EVAL_FIRST_FAIL_EN
   assign first_fail_valid  = r_ff_valid;
   assign first_fail_vector = r_ff_vector;
`endif

endmodule

`default_nettype wire
